// File: rtl/pipe_gap_gen_pkg.sv
// Shared definitions for the pipe-gap generator: FSM states, LFSR taps and the
// level-to-position mapping.
package pipe_gap_gen_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Right-shifting Galois step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LfsrTaps : 16'h0000);
  endfunction

  function automatic int unsigned level_to_gap(int unsigned gap_min, int unsigned gap_step,
                                               int unsigned lvl);
    return gap_min + lvl * gap_step;
  endfunction

endpackage

// File: rtl/pipe_gap_gen_lfsr.sv
// 16-bit Galois LFSR with tick enable, seed load and a guard that substitutes
// the fixed seed whenever the next value would be zero.
module gap_lfsr
  import pipe_gap_gen_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d, cand;

  always_comb begin
    cand   = load_i ? seed_i : lfsr_step(lfsr_q);
    lfsr_d = lfsr_q;
    if (tick_i) begin
      lfsr_d = (cand == 16'h0000) ? LFSR_SEED : cand;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pipe_gap_gen.sv
// Pipe-gap generator: queues pipe wraps, serves the lowest pending pipe once per
// tick with a slew-limited random gap level, and ends the game with END_GAP.
module pipe_gap_gen
  import pipe_gap_gen_pkg::*;
#(
  parameter int unsigned   NUM_PIPES  = 2,
  parameter int unsigned   GAP_W      = 16,
  parameter int unsigned   GAP_MIN    = 40,
  parameter int unsigned   GAP_STEP   = 20,
  parameter int unsigned   GAP_LEVELS = 7,
  parameter int unsigned   MAX_DELTA  = 3,
  parameter int unsigned   SEQ_LEN    = 50,
  parameter int unsigned   END_GAP    = 395,
  parameter logic [15:0]   LFSR_SEED  = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         tick_i,
  input  logic                         button_n_i,
  input  logic [NUM_PIPES-1:0]         pipe_wrap_i,
  output logic [NUM_PIPES*GAP_W-1:0]   gap_o,
  output logic [NUM_PIPES-1:0]         gap_valid_o,
  output logic [7:0]                   issued_o,
  output logic                         running_o,
  output logic                         done_o
);

  localparam logic [GAP_W-1:0] GapInit = GAP_W'(level_to_gap(GAP_MIN, GAP_STEP, GAP_LEVELS / 2));

  state_e                              state_q, state_d;
  logic [NUM_PIPES-1:0]                pending_q, pending_d;
  logic [2:0]                          prev_level_q, prev_level_d;
  logic [7:0]                          issued_q, issued_d;
  logic [NUM_PIPES-1:0][GAP_W-1:0]     gap_q, gap_d;
  logic [NUM_PIPES-1:0]                gap_valid_q, gap_valid_d;

  logic [15:0]          lfsr;
  logic                 lfsr_load;
  logic [15:0]          seed;
  logic [NUM_PIPES-1:0] serve_oh;
  logic [GAP_W-1:0]     new_gap;
  int unsigned          raw_lvl, prev_lvl, lo_lvl, hi_lvl, new_lvl;

  gap_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_i (tick_i),
    .load_i (lfsr_load),
    .seed_i (seed),
    .lfsr_o (lfsr)
  );

  assign seed     = lfsr ^ {issued_q, 8'h5A};
  // Isolate the lowest set pending bit.
  assign serve_oh = pending_q & (~pending_q + NUM_PIPES'(1));

  always_comb begin
    raw_lvl = 32'(lfsr[2:0]);
    if (raw_lvl >= GAP_LEVELS) begin
      raw_lvl = raw_lvl - GAP_LEVELS;
    end
    prev_lvl = 32'(prev_level_q);
    lo_lvl   = (prev_lvl >= MAX_DELTA) ? prev_lvl - MAX_DELTA : 0;
    hi_lvl   = prev_lvl + MAX_DELTA;
    if (hi_lvl > GAP_LEVELS - 1) begin
      hi_lvl = GAP_LEVELS - 1;
    end
    if (raw_lvl < lo_lvl) begin
      new_lvl = lo_lvl;
    end else if (raw_lvl > hi_lvl) begin
      new_lvl = hi_lvl;
    end else begin
      new_lvl = raw_lvl;
    end
    new_gap = GAP_W'(level_to_gap(GAP_MIN, GAP_STEP, new_lvl));
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    prev_level_d = prev_level_q;
    issued_d     = issued_q;
    gap_d        = gap_q;
    gap_valid_d  = '0;
    lfsr_load    = 1'b0;

    if (tick_i) begin
      case (state_q)
        StIdle: begin
          if (!button_n_i) begin
            state_d   = StRun;
            lfsr_load = 1'b1;
          end
        end
        StRun: begin
          // A wrap on the pipe being served re-arms it after the clear.
          pending_d = (pending_q & ~serve_oh) | pipe_wrap_i;
          if (|pending_q) begin
            gap_valid_d = serve_oh;
            if (issued_q == 8'(SEQ_LEN - 1)) begin
              for (int k = 0; k < NUM_PIPES; k++) begin
                if (serve_oh[k]) gap_d[k] = GAP_W'(END_GAP);
              end
              issued_d  = 8'(SEQ_LEN);
              state_d   = StDone;
              pending_d = '0;
            end else begin
              for (int k = 0; k < NUM_PIPES; k++) begin
                if (serve_oh[k]) gap_d[k] = new_gap;
              end
              prev_level_d = 3'(new_lvl);
              issued_d     = issued_q + 8'd1;
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      prev_level_q <= 3'(GAP_LEVELS / 2);
      issued_q     <= '0;
      gap_q        <= {NUM_PIPES{GapInit}};
      gap_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      prev_level_q <= prev_level_d;
      issued_q     <= issued_d;
      gap_q        <= gap_d;
      gap_valid_q  <= gap_valid_d;
    end
  end

  assign gap_o       = gap_q;
  assign gap_valid_o = gap_valid_q;
  assign issued_o    = issued_q;
  assign running_o   = (state_q == StRun);
  assign done_o      = (state_q == StDone);

endmodule
